// File: rtl/pattern_event_logger_if.sv
// -----------------------------------------------------------------------------
// pattern_event_logger_if
// Read-side valid/ready port of the pattern event logger FIFO.
//   rd_valid : FIFO head holds a valid entry (driven by the logger)
//   rd_ready : reader accepts the head this cycle (driven by the reader)
//   rd_data  : {kind, timestamp} of the head entry (driven by the logger)
// Modports: master = logger side, slave = reader side.
// -----------------------------------------------------------------------------
interface pattern_event_logger_if #(
   parameter int DW = 9
);
   logic          rd_valid;
   logic          rd_ready;
   logic [DW-1:0] rd_data;

   modport master (output rd_valid, output rd_data, input rd_ready);
   modport slave  (input rd_valid, input rd_data, output rd_ready);
endinterface

// File: rtl/pattern_event_logger.sv
// -----------------------------------------------------------------------------
// pattern_event_logger
// Consumes the 2-bit code of a 3-bit Mealy pattern detector, counts 001/111
// events, timestamps each one and queues it in a small FIFO that is drained
// over a valid/ready read port.
//
// Ports:
//   clock       : single clock, posedge
//   reset_n     : asynchronous active-low reset
//   code        : 10 = pattern 001, 01 = pattern 111, 00 = none, 11 = illegal
//   stats_clear : synchronous statistics clear (only with PATLOG_STATS_CLEAR_EN)
//   rd          : read port (rd_valid / rd_ready / rd_data = {kind, ts})
//   cnt_001     : saturating count of 001 events
//   cnt_111     : saturating count of 111 events
//   drop_cnt    : saturating count of events lost to a full FIFO
//   err         : sticky flag, set when code 11 is sampled
//   level       : current FIFO occupancy
//
// Optional feature macro: PATLOG_STATS_CLEAR_EN adds the stats_clear input.
// -----------------------------------------------------------------------------
module pattern_event_logger #(
   parameter int DEPTH = 4,
   parameter int TS_W  = 8,
   parameter int CNT_W = 8
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic [1:0]              code,
`ifdef PATLOG_STATS_CLEAR_EN
   input  logic                    stats_clear,
`endif
   pattern_event_logger_if.master  rd,
   output logic [CNT_W-1:0]        cnt_001,
   output logic [CNT_W-1:0]        cnt_111,
   output logic [CNT_W-1:0]        drop_cnt,
   output logic                    err,
   output logic [$clog2(DEPTH):0]  level
);

   localparam int AW = $clog2(DEPTH);

   localparam logic [1:0]       CODE_001 = 2'b10;
   localparam logic [1:0]       CODE_111 = 2'b01;
   localparam logic [1:0]       CODE_BAD = 2'b11;
   localparam logic [AW:0]      PTR_ONE  = {{AW{1'b0}}, 1'b1};
   localparam logic [TS_W-1:0]  TS_ONE   = {{(TS_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   logic [TS_W-1:0]  r_ts;
   logic [AW:0]      r_wptr;
   logic [AW:0]      r_rptr;
   logic [TS_W:0]    r_mem [DEPTH];
   logic [CNT_W-1:0] r_cnt_001;
   logic [CNT_W-1:0] r_cnt_111;
   logic [CNT_W-1:0] r_drop;
   logic             r_err;

   logic             w_clear;
   logic             w_event;
   logic             w_kind;
   logic             w_illegal;
   logic             w_empty;
   logic             w_full;
   logic             w_pop;
   logic             w_push;
   logic             w_drop;
   logic [CNT_W-1:0] w_base_001;
   logic [CNT_W-1:0] w_base_111;
   logic [CNT_W-1:0] w_base_drop;
   logic             w_base_err;

   // Saturating increment: holds at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                input logic             en);
      if (en && (v != CNT_MAX)) begin
         sat_inc = v + CNT_ONE;
      end else begin
         sat_inc = v;
      end
   endfunction

`ifdef PATLOG_STATS_CLEAR_EN
   assign w_clear = stats_clear;
`else
   assign w_clear = 1'b0;
`endif

   // Decode the detector code into event / kind / illegal strobes.
   always_comb begin
      w_event   = 1'b0;
      w_kind    = 1'b0;
      w_illegal = 1'b0;
      case (code)
         CODE_001: begin
            w_event = 1'b1;
            w_kind  = 1'b1;
         end
         CODE_111: begin
            w_event = 1'b1;
         end
         CODE_BAD: begin
            w_illegal = 1'b1;
         end
         default: begin
            w_event = 1'b0;
         end
      endcase
   end

   // FIFO status: pointers carry one extra wrap bit so full and empty differ
   // only in the MSB. A pop frees a slot in the same cycle, so a full FIFO
   // still accepts an event when the head is being read.
   always_comb begin
      w_empty = (r_wptr == r_rptr);
      w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
      w_pop   = !w_empty && rd.rd_ready;
      w_push  = w_event && (!w_full || w_pop);
      w_drop  = w_event && w_full && !w_pop;
   end

   // Statistics start from zero in a clear cycle so a coincident event reads 1.
   always_comb begin
      w_base_001  = r_cnt_001;
      w_base_111  = r_cnt_111;
      w_base_drop = r_drop;
      w_base_err  = r_err;
      if (w_clear) begin
         w_base_001  = CNT_ZERO;
         w_base_111  = CNT_ZERO;
         w_base_drop = CNT_ZERO;
         w_base_err  = 1'b0;
      end else begin
         w_base_err  = r_err;
      end
   end

   // Timestamp counter and FIFO pointers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_ts   <= {TS_W{1'b0}};
         r_wptr <= {(AW+1){1'b0}};
         r_rptr <= {(AW+1){1'b0}};
      end else begin
         r_ts <= r_ts + TS_ONE;
         if (w_push) begin
            r_wptr <= r_wptr + PTR_ONE;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + PTR_ONE;
         end
      end
   end

   // FIFO storage; the entry records ts as it was before this edge's increment.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= {(TS_W+1){1'b0}};
         end
      end else begin
         if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= {w_kind, r_ts};
         end
      end
   end

   // Saturating statistics counters and sticky illegal-code flag.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt_001 <= CNT_ZERO;
         r_cnt_111 <= CNT_ZERO;
         r_drop    <= CNT_ZERO;
         r_err     <= 1'b0;
      end else begin
         r_cnt_001 <= sat_inc(w_base_001, w_event && w_kind);
         r_cnt_111 <= sat_inc(w_base_111, w_event && !w_kind);
         r_drop    <= sat_inc(w_base_drop, w_drop);
         r_err     <= w_base_err | w_illegal;
      end
   end

   // Outputs are decoded from registers only; rd_data reads 0 while empty.
   assign rd.rd_valid = !w_empty;
   assign rd.rd_data  = w_empty ? {(TS_W+1){1'b0}} : r_mem[r_rptr[AW-1:0]];
   assign level       = r_wptr - r_rptr;
   assign cnt_001     = r_cnt_001;
   assign cnt_111     = r_cnt_111;
   assign drop_cnt    = r_drop;
   assign err         = r_err;

endmodule

// File: tb/tb_pattern_event_logger.sv
module tb_pattern_event_logger;

   logic       clock;
   logic       reset_n;
   logic [1:0] code;
   logic [7:0] cnt_001, cnt_111, drop_cnt;
   logic       err;
   logic [2:0] level;

   logic       s_rst_n;
   logic [1:0] s_code;
   logic       s_clear;
   logic [1:0] s_cnt_001, s_cnt_111, s_drop;
   logic       s_err;
   logic [2:0] s_level;

   int n_cmp = 0;
   int n_fail = 0;

   pattern_event_logger_if #(.DW(9)) m_if ();
   pattern_event_logger_if #(.DW(4)) s_if ();

   pattern_event_logger #(.DEPTH(4), .TS_W(8), .CNT_W(8)) dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .code     (code),
`ifdef PATLOG_STATS_CLEAR_EN
      .stats_clear (1'b0),
`endif
      .rd       (m_if.master),
      .cnt_001  (cnt_001),
      .cnt_111  (cnt_111),
      .drop_cnt (drop_cnt),
      .err      (err),
      .level    (level)
   );

   pattern_event_logger #(.DEPTH(4), .TS_W(3), .CNT_W(2)) dut_s (
      .clock    (clock),
      .reset_n  (s_rst_n),
      .code     (s_code),
`ifdef PATLOG_STATS_CLEAR_EN
      .stats_clear (s_clear),
`endif
      .rd       (s_if.master),
      .cnt_001  (s_cnt_001),
      .cnt_111  (s_cnt_111),
      .drop_cnt (s_drop),
      .err      (s_err),
      .level    (s_level)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ---------------- reference model (queue + plain counters) ----------------
   logic [8:0] mq[$];
   int         m_ts, m_c001, m_c111, m_drop;
   logic       m_err;

   task automatic model_reset();
      mq.delete();
      m_ts = 0; m_c001 = 0; m_c111 = 0; m_drop = 0; m_err = 1'b0;
   endtask

   task automatic model_step(input logic [1:0] c, input logic r);
      bit pop, full, ev;
      logic [8:0] e;
      full = (mq.size() == 4);
      pop  = (mq.size() > 0) && r;
      ev   = (c == 2'b10) || (c == 2'b01);
      e    = {(c == 2'b10), m_ts[7:0]};
      if (pop) void'(mq.pop_front());
      if (ev) begin
         if (!full || pop) mq.push_back(e);
         else if (m_drop < 255) m_drop++;
         if (c == 2'b10 && m_c001 < 255) m_c001++;
         if (c == 2'b01 && m_c111 < 255) m_c111++;
      end
      if (c == 2'b11) m_err = 1'b1;
      m_ts = (m_ts + 1) % 256;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                  name, act, act, exp, exp, $time);
      end
   endtask

   task automatic step(input logic [1:0] c, input logic r);
      code = c;
      m_if.rd_ready = r;
      @(posedge clock);
      model_step(c, r);
      #1;
   endtask

   task automatic compare_model(input string tag);
      chk({tag, ".valid"}, int'(m_if.rd_valid), int'(mq.size() > 0));
      if (mq.size() > 0) chk({tag, ".data"}, int'(m_if.rd_data), int'(mq[0]));
      chk({tag, ".level"}, int'(level), mq.size());
      chk({tag, ".cnt001"}, int'(cnt_001), m_c001);
      chk({tag, ".cnt111"}, int'(cnt_111), m_c111);
      chk({tag, ".drop"}, int'(drop_cnt), m_drop);
      chk({tag, ".err"}, int'(err), int'(m_err));
   endtask

   task automatic s_step(input logic [1:0] c, input logic r);
      s_code = c;
      s_if.rd_ready = r;
      @(posedge clock);
      #1;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic [1:0] code;
      logic       rdy;
      logic       v;
      logic [8:0] data;
      int         lvl;
      int         c1;
      int         c7;
      int         dr;
      logic       er;
   } vec_t;

   function automatic vec_t mk(logic [1:0] c, logic r, logic v, logic [8:0] d,
                               int l, int c1, int c7, int dr, logic er);
      vec_t t;
      t.code = c; t.rdy = r; t.v = v; t.data = d; t.lvl = l;
      t.c1 = c1; t.c7 = c7; t.dr = dr; t.er = er;
      return t;
   endfunction

   vec_t tbl[19];

   initial begin
      // single event, then pop
      tbl[0]  = mk(2'b10, 1'b0, 1'b1, 9'h100, 1, 1, 0, 0, 1'b0);
      tbl[1]  = mk(2'b00, 1'b1, 1'b0, 9'h000, 0, 1, 0, 0, 1'b0);
      tbl[2]  = mk(2'b00, 1'b0, 1'b0, 9'h000, 0, 1, 0, 0, 1'b0);
      tbl[3]  = mk(2'b00, 1'b0, 1'b0, 9'h000, 0, 1, 0, 0, 1'b0);
      tbl[4]  = mk(2'b00, 1'b0, 1'b0, 9'h000, 0, 1, 0, 0, 1'b0);
      // run of 1s at ts 5,6,7 then drain
      tbl[5]  = mk(2'b01, 1'b0, 1'b1, 9'h005, 1, 1, 1, 0, 1'b0);
      tbl[6]  = mk(2'b01, 1'b0, 1'b1, 9'h005, 2, 1, 2, 0, 1'b0);
      tbl[7]  = mk(2'b01, 1'b0, 1'b1, 9'h005, 3, 1, 3, 0, 1'b0);
      tbl[8]  = mk(2'b00, 1'b1, 1'b1, 9'h006, 2, 1, 3, 0, 1'b0);
      tbl[9]  = mk(2'b00, 1'b1, 1'b1, 9'h007, 1, 1, 3, 0, 1'b0);
      tbl[10] = mk(2'b00, 1'b1, 1'b0, 9'h000, 0, 1, 3, 0, 1'b0);
      // overflow: 6 events at ts 11..16 with reader stalled
      tbl[11] = mk(2'b10, 1'b0, 1'b1, 9'h10B, 1, 2, 3, 0, 1'b0);
      tbl[12] = mk(2'b01, 1'b0, 1'b1, 9'h10B, 2, 2, 4, 0, 1'b0);
      tbl[13] = mk(2'b10, 1'b0, 1'b1, 9'h10B, 3, 3, 4, 0, 1'b0);
      tbl[14] = mk(2'b01, 1'b0, 1'b1, 9'h10B, 4, 3, 5, 0, 1'b0);
      tbl[15] = mk(2'b10, 1'b0, 1'b1, 9'h10B, 4, 4, 5, 1, 1'b0);
      tbl[16] = mk(2'b01, 1'b0, 1'b1, 9'h10B, 4, 4, 6, 2, 1'b0);
      // event while full with a pop: accepted, no drop
      tbl[17] = mk(2'b10, 1'b1, 1'b1, 9'h00C, 4, 5, 6, 2, 1'b0);
      // illegal code: err set, nothing pushed or counted
      tbl[18] = mk(2'b11, 1'b0, 1'b1, 9'h00C, 4, 5, 6, 2, 1'b1);

      reset_n = 1'b0;
      s_rst_n = 1'b0;
      code = 2'b00;
      s_code = 2'b00;
      s_clear = 1'b0;
      m_if.rd_ready = 1'b0;
      s_if.rd_ready = 1'b0;
      model_reset();
      repeat (3) @(posedge clock);
      #1;
      chk("rst.valid", int'(m_if.rd_valid), 0);
      chk("rst.data", int'(m_if.rd_data), 0);
      chk("rst.level", int'(level), 0);
      chk("rst.cnt001", int'(cnt_001), 0);
      chk("rst.cnt111", int'(cnt_111), 0);
      chk("rst.drop", int'(drop_cnt), 0);
      chk("rst.err", int'(err), 0);
      @(negedge clock);
      reset_n = 1'b1;

      for (int i = 0; i < 19; i++) begin
         step(tbl[i].code, tbl[i].rdy);
         chk($sformatf("vec%0d.valid", i), int'(m_if.rd_valid), int'(tbl[i].v));
         if (tbl[i].v)
            chk($sformatf("vec%0d.data", i), int'(m_if.rd_data), int'(tbl[i].data));
         chk($sformatf("vec%0d.level", i), int'(level), tbl[i].lvl);
         chk($sformatf("vec%0d.cnt001", i), int'(cnt_001), tbl[i].c1);
         chk($sformatf("vec%0d.cnt111", i), int'(cnt_111), tbl[i].c7);
         chk($sformatf("vec%0d.drop", i), int'(drop_cnt), tbl[i].dr);
         chk($sformatf("vec%0d.err", i), int'(err), int'(tbl[i].er));
      end

      // err must stay set across idle cycles
      for (int i = 0; i < 10; i++) begin
         step(2'b00, 1'b0);
         chk("idle.err", int'(err), 1);
      end
      compare_model("idle");

      // reset in the middle of a drain with 3 entries queued
      step(2'b00, 1'b1);
      chk("drain.level", int'(level), 3);
      #2;
      reset_n = 1'b0;
      #1;
      chk("midrst.valid", int'(m_if.rd_valid), 0);
      chk("midrst.level", int'(level), 0);
      chk("midrst.err", int'(err), 0);
      model_reset();
      @(negedge clock);
      reset_n = 1'b1;
      step(2'b10, 1'b0);
      chk("postrst.data", int'(m_if.rd_data), 9'h100);
      compare_model("postrst");

      // randomized traffic against the reference model
      for (int i = 0; i < 600; i++) begin
         logic [1:0] c;
         logic       r;
         int         sel;
         sel = $urandom_range(0, 99);
         if (sel < 35)      c = 2'b10;
         else if (sel < 70) c = 2'b01;
         else if (sel < 99) c = 2'b00;
         else               c = 2'b11;
         if (i < 300) r = ($urandom_range(0, 3) == 0);
         else         r = ($urandom_range(0, 3) != 0);
         step(c, r);
         compare_model("rand");
      end

      // small instance: CNT_W = 2, TS_W = 3, saturation and ts wrap
      @(negedge clock);
      s_rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         s_step(2'b10, 1'b1);
         chk($sformatf("sat%0d.cnt001", k), int'(s_cnt_001), (k + 1 > 3) ? 3 : k + 1);
      end
      s_step(2'b00, 1'b1);
      chk("sat.drain_level", int'(s_level), 0);
      s_step(2'b00, 1'b1);
      s_step(2'b00, 1'b1);
      s_step(2'b10, 1'b0);
      chk("wrap.valid", int'(s_if.rd_valid), 1);
      chk("wrap.data", int'(s_if.rd_data), 4'h8);
      chk("wrap.cnt001", int'(s_cnt_001), 3);
      chk("wrap.level", int'(s_level), 1);
      chk("wrap.drop", int'(s_drop), 0);
`ifdef PATLOG_STATS_CLEAR_EN
      s_clear = 1'b1;
      s_step(2'b00, 1'b0);
      s_clear = 1'b0;
      chk("clr.cnt001", int'(s_cnt_001), 0);
      chk("clr.level", int'(s_level), 1);
      s_clear = 1'b1;
      s_step(2'b10, 1'b0);
      s_clear = 1'b0;
      chk("clr_ev.cnt001", int'(s_cnt_001), 1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
